data_register_reader: RTL and testbench

Read-side controller for the 256x8 data_register storage block. On a start command it walks a contiguous address range (start address, length), drives the register file's read_addr, and samples its combinational read_data. It streams the words out over a valid/ready interface with a last marker. It sits between the data_register and any downstream consumer, such as a transmitter or checker, and sustains one word per clock when the consumer is not stalling.

---
 rtl/data_register_pkg.sv | 14 +
 rtl/data_register_reader.sv | 85 ++++++++
 tb/tb_data_register_reader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_register_pkg.sv
// Shared widths and state encoding for the data_register storage block
// and its read-side streaming controller.
package data_register_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam int LEN_WIDTH  = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/data_register_reader.sv
// Walks a contiguous address range of the data_register and streams the
// words out over valid/ready with a last marker, one word per clock.
module data_register_reader
    import data_register_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    state_t               state;
    state_t               next_state;
    logic [LEN_WIDTH-1:0] fetch_left;
    logic                 accept_start;
    logic                 zero_start;
    logic                 load;
    logic                 finish;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_start) next_state = RUN;
            RUN:     if (finish)       next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The output register refills whenever it is empty or being drained,
    // so a handshake and a load share the same edge for full throughput.
    always_comb begin
        accept_start = (state == IDLE) && start && (length != '0);
        zero_start   = (state == IDLE) && start && (length == '0);
        load         = (state == RUN) && (!out_valid || out_ready) && (fetch_left != '0);
        finish       = (state == RUN) && out_valid && out_ready && out_last;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            read_addr  <= '0;
            fetch_left <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            done <= finish || zero_start;
            if (accept_start) begin
                read_addr  <= start_addr;
                fetch_left <= length;
                busy       <= 1'b1;
            end
            if (load) begin
                out_data   <= read_data;
                out_valid  <= 1'b1;
                out_last   <= (fetch_left == LEN_WIDTH'(1));
                read_addr  <= read_addr + ADDR_WIDTH'(1);
                fetch_left <= fetch_left - LEN_WIDTH'(1);
            end else if (finish) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_register_reader.sv
// Self-checking bench for data_register_reader: a behavioural 256x8 memory
// with combinational read feeds the reader; streamed words are scored.
module tb_data_register_reader;
    import data_register_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] start_addr = '0;
    logic [LEN_WIDTH-1:0]  length = '0;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  out_last;

    logic [DATA_WIDTH-1:0] mem [256];
    int checks = 0;
    int failures = 0;

    assign read_data = mem[read_addr];

    always #5 clock = ~clock;

    data_register_reader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    typedef struct {
        logic [7:0] addr;
        logic [8:0] len;
        int         mode;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_last"}, 32'(out_last), 0);
        checkOutput({tag, "_data"}, 32'(out_data), 0);
        checkOutput({tag, "_addr"}, 32'(read_addr), 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: three stall cycles on the second word
    task automatic applyStimulus(input logic [7:0] addr, input logic [8:0] len, input int mode,
                                 output logic [7:0] first_word, output logic [7:0] last_word,
                                 output int n_words);
        logic [7:0] exp_q[$];
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        logic [7:0] prev_addr = '0;
        int         stalls = 0;
        bit         finished = 0;
        first_word = '0;
        last_word  = '0;
        n_words    = 0;
        for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[(int'(addr) + i) % 256]);

        @(negedge clock);
        start = 1'b1; start_addr = addr; length = len; out_ready = (mode != 1) ? 1'b1 : 1'b0;
        @(negedge clock);
        start = 1'b0;
        checkOutput("start_valid", 32'(out_valid), 0);
        if (len == 0) begin
            checkOutput("zero_done", 32'(done), 1);
            checkOutput("zero_busy", 32'(busy), 0);
            @(negedge clock);
            checkOutput("zero_done_off", 32'(done), 0);
            checkOutput("zero_valid", 32'(out_valid), 0);
            checkOutput("zero_busy2", 32'(busy), 0);
            return;
        end
        checkOutput("start_addr", 32'(read_addr), 32'(addr));
        checkOutput("start_busy", 32'(busy), 1);

        for (int cyc = 0; cyc < int'(len) * 4 + 50 && !finished; cyc++) begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(out_valid), 1);
                checkOutput("stall_data", 32'(out_data), 32'(prev_data));
                checkOutput("stall_last", 32'(out_last), 32'(prev_last));
                checkOutput("stall_addr", 32'(read_addr), 32'(prev_addr));
            end
            checkOutput("run_done", 32'(done), 0);
            if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && n_words == 1 && out_valid && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else out_ready = 1'b1;

            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_addr  = read_addr;

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_word", 1, 0);
                    finished = 1;
                end else begin
                    checkOutput("word_data", 32'(out_data), 32'(exp_q[0]));
                    checkOutput("word_last", 32'(out_last), 32'(exp_q.size() == 1));
                    if (n_words == 0) first_word = out_data;
                    last_word = out_data;
                    n_words++;
                    void'(exp_q.pop_front());
                    if (out_last) finished = 1;
                end
            end
            @(negedge clock);
        end
        if (!finished) checkOutput("timeout", 0, 1);
        out_ready = 1'b0;
        checkOutput("end_done", 32'(done), 1);
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_valid", 32'(out_valid), 0);
        @(negedge clock);
        checkOutput("end_done_off", 32'(done), 0);
    endtask

    initial begin
        logic [7:0] fw, lw;
        int         nw;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 4);
        mem[255] = 8'hAA;

        vecs[0] = '{addr: 8'd0,   len: 9'd3,   mode: 0, exp_first: 8'h04, exp_last: 8'h06};
        vecs[1] = '{addr: 8'd0,   len: 9'd3,   mode: 2, exp_first: 8'h04, exp_last: 8'h06};
        vecs[2] = '{addr: 8'd255, len: 9'd2,   mode: 0, exp_first: 8'hAA, exp_last: 8'h04};
        vecs[3] = '{addr: 8'd7,   len: 9'd0,   mode: 0, exp_first: 8'h00, exp_last: 8'h00};
        vecs[4] = '{addr: 8'd10,  len: 9'd256, mode: 1, exp_first: 8'h0E, exp_last: 8'h0D};
        vecs[5] = '{addr: 8'd250, len: 9'd10,  mode: 1, exp_first: 8'hFE, exp_last: 8'h07};

        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkIdleOutputs("reset");
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].len, vecs[v].mode, fw, lw, nw);
            checkOutput($sformatf("vec%0d_count", v), 32'(nw), 32'(vecs[v].len));
            if (vecs[v].len != 0) begin
                checkOutput($sformatf("vec%0d_first", v), 32'(fw), 32'(vecs[v].exp_first));
                checkOutput($sformatf("vec%0d_last", v), 32'(lw), 32'(vecs[v].exp_last));
            end
        end

        // Second start mid-transfer is ignored, then reset aborts silently.
        @(negedge clock);
        start = 1'b1; start_addr = 8'd0; length = 9'd3; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checkOutput("abort_w0", 32'(out_data), 32'h04);
        start = 1'b1; start_addr = 8'd50; length = 9'd5;
        @(negedge clock);
        start = 1'b0;
        checkOutput("abort_w1", 32'(out_data), 32'h05);
        checkOutput("abort_w1_valid", 32'(out_valid), 1);
        checkOutput("abort_addr", 32'(read_addr), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        checkIdleOutputs("abort");
        reset = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checkOutput("abort_no_done", 32'(done), 0);
            checkOutput("abort_no_valid", 32'(out_valid), 0);
        end
        applyStimulus(8'd1, 9'd2, 0, fw, lw, nw);
        checkOutput("restart_count", 32'(nw), 2);
        checkOutput("restart_first", 32'(fw), 32'h05);
        checkOutput("restart_last", 32'(lw), 32'h06);

        // Full-range read of an identity pattern.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        applyStimulus(8'd0, 9'd256, 0, fw, lw, nw);
        checkOutput("full_count", 32'(nw), 256);
        checkOutput("full_first", 32'(fw), 0);
        checkOutput("full_last", 32'(lw), 255);

        // Random contents, ranges and backpressure.
        for (int t = 0; t < 8; t++) begin
            logic [7:0] ra;
            logic [8:0] rl;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            ra = 8'($urandom);
            rl = (t == 7) ? 9'd256 : 9'($urandom_range(1, 40));
            applyStimulus(ra, rl, 1, fw, lw, nw);
            checkOutput("rand_count", 32'(nw), 32'(rl));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
